i2c_cmd_arbiter: RTL and testbench
==================================

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000: maximum clk cycles allowed from transaction issue to m_done.
REQ-002 clk  in  1  single system clock; all logic on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester transaction request; held high until its done pulse.
REQ-005 req_rw  in  2  per-requester direction; 1 = read, 0 = write.
REQ-006 req_addr  in  14  two packed 7-bit slave addresses; requester 0 is bits [6:0].
REQ-007 req_wdata  in  16  two packed write bytes; requester 0 is bits [7:0].
REQ-008 gnt  out  2  one-hot grant pulse, one cycle long, given when a request is accepted.
REQ-009 done  out  2  one-hot completion pulse, one cycle long, to the owning requester.
REQ-010 rdata  out  8  read byte; valid in the done cycle.
REQ-011 err  out  2  error code, valid in the done cycle: 00 = ok, 01 = NACK, 10 = timeout.
REQ-012 m_ena  out  1  start pulse to the I2C master core, one cycle long.
REQ-013 m_rw, m_addr[6:0], m_wdata[7:0]  out  command fields to the master; held stable from m_ena until m_done.
REQ-014 m_busy  in  1  master core is in a non-idle state.
REQ-015 m_done  in  1  one-cycle pulse when the master returns to idle after STOP.
REQ-016 m_rdata[7:0], m_ack_err  in  read byte and NACK flag from the master; sampled when m_done is high.

Function
REQ-017 FSM states: IDLE, ARB, ISSUE, WAIT, RESP; encoding is 3-bit binary.
REQ-018 IDLE -> ARB when |req is high and m_busy is low; otherwise stay in IDLE.
REQ-019 ARB: round-robin pick.
- The last-served pointer `last` starts at 1 out of reset, so requester 0 wins the first contention.
- The winner is the first asserted req after `last`.
- The winner's fields are latched into m_rw, m_addr and m_wdata.
- Owner and `last` update to the winner; gnt[winner] pulses.
- Next state is ISSUE.
REQ-020 ISSUE: m_ena=1 for exactly one cycle; clear timeout counter; -> WAIT.
REQ-021 WAIT: counter increments every cycle.
- m_done=1 -> RESP, with err=01 if m_ack_err is set, else 00, and rdata latched from m_rdata.
- Counter reaches TIMEOUT_CYC-1 without m_done -> RESP with err=10.
- If m_done and timeout occur in the same cycle, m_done wins.
REQ-022 RESP: done[owner] pulses one cycle; rdata/err held until the next RESP; -> IDLE.
REQ-023 Total latency: gnt arrives 2 cycles after req is seen in IDLE, and m_ena 1 cycle after gnt.
REQ-024 Request changes:
- A request dropped before grant is ignored.
- A request dropped after grant still completes and pulses done.
REQ-025 If both requesters are asserted continuously, grants alternate 0,1,0,1 with no starvation.
REQ-026 gnt, done and m_ena are never high in the same cycle; at most one transaction is outstanding.
REQ-027 The timeout counter is 16 bits wide and saturates; it never wraps.
REQ-028 A m_done pulse outside WAIT is ignored.

Reset
REQ-029 With rst=1 at a clk edge, all of the following clear, even mid-transaction:
- state=IDLE, last=1, counter=0;
- gnt=0, done=0, m_ena=0, err=00, rdata=0;
- m_rw=0, m_addr=0, m_wdata=0.
REQ-030 A transaction in flight at reset produces no done pulse; the master core is reset by the same rst.

Structure
REQ-031 Shared package i2c_pkg holds:
- FSM state localparams;
- error codes ERR_OK, ERR_NACK, ERR_TMO;
- address width 7 and data width 8.
The existing master-core state codes move there as well.
REQ-032 The round-robin picker is one combinational sub-module, i2c_rr_pick (inputs req[1:0] and last; outputs one-hot win[1:0]).
REQ-033 The block is RTL only, with no vendor primitives, and is sized at 120-400 lines.

Verification
REQ-034 Single write: req=01, addr0=0x50, wdata0=0xA5; master returns m_done with m_ack_err=0.
- Expected: gnt=01; m_ena one cycle later with m_addr=0x50, m_wdata=0xA5, m_rw=0.
- Expected: done=01 with err=00.
REQ-035 Read: req=10, rw1=1, addr1=0x3C; master returns m_rdata=0x7E.
- Expected: done=10, rdata=0x7E, err=00.
REQ-036 Contention: req=11 held for 4 transactions.
- Expected: gnt sequence 01, 10, 01, 10.
REQ-037 NACK: m_ack_err=1 at m_done.
- Expected: err=01, done pulses once, FSM returns to IDLE.
REQ-038 Timeout: TIMEOUT_CYC=20 and m_done never arrives.
- Expected: done pulse with err=10 exactly 20 cycles after m_ena.
REQ-039 Reset mid-WAIT: assert rst for 1 cycle.
- Expected: outputs are zero, no done pulse, and a new request is served normally with requester 0 first.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C command arbiter and master core
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        MC_IDLE  = 3'd0,
        MC_START = 3'd1,
        MC_ADDR  = 3'd2,
        MC_ACK1  = 3'd3,
        MC_DATA  = 3'd4,
        MC_ACK2  = 3'd5,
        MC_STOP  = 3'd6
    } mc_state_t;

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// rtl/i2c_cmd_arbiter_if.sv - command/response bus between the arbiter and the I2C master core
interface i2c_cmd_arbiter_if;
    import i2c_pkg::*;

    logic              m_ena;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_busy;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack_err;

    modport master (
        output m_ena, m_rw, m_addr, m_wdata,
        input  m_busy, m_done, m_rdata, m_ack_err
    );

    modport slave (
        input  m_ena, m_rw, m_addr, m_wdata,
        output m_busy, m_done, m_rdata, m_ack_err
    );

endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - two-way round-robin picker, first asserted request after the last served one
module i2c_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    assign win[0] = req[0] & (last | ~req[1]);
    assign win[1] = req[1] & (~last | ~req[0]);

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - arbitrates two requesters onto one I2C master core with timeout
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            req_rw,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            err,
    i2c_cmd_arbiter_if.master     m_if
);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ena_q, ena_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        win;

    i2c_rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    // Every output is registered on leaving a state, so it is visible during the following one.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        ena_d   = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|req && !m_if.m_busy) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|win) begin
                    rw_d    = win[1] ? req_rw[1] : req_rw[0];
                    addr_d  = win[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    wdata_d = win[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    last_d  = win[1];
                    gnt_d   = win;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ena_d   = 1'b1;
                cnt_d   = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (m_if.m_done) begin
                    done_d  = last_q ? 2'b10 : 2'b01;
                    err_d   = m_if.m_ack_err ? ERR_NACK : ERR_OK;
                    rdata_d = m_if.m_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                    done_d  = last_q ? 2'b10 : 2'b01;
                    err_d   = ERR_TMO;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= ERR_OK;
            rdata_q <= '0;
            ena_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ena_q   <= ena_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign m_if.m_ena     = ena_q;
    assign m_if.m_rw      = rw_q;
    assign m_if.m_addr    = addr_q;
    assign m_if.m_wdata   = wdata_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - scoreboard bench for the I2C command arbiter
module tb_i2c_cmd_arbiter;
    import i2c_pkg::*;

    typedef struct {
        logic [1:0] done;
        logic [1:0] err;
        logic [7:0] rdata;
        int         lat;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_rw = 2'b00;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  rdata;

    i2c_cmd_arbiter_if mif ();

    i2c_cmd_arbiter #(.TIMEOUT_CYC(16'd20)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .m_if      (mif.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ena_cyc = 0;
    int stray_cnt = 0;
    int stray_seen = 0;
    int mm_delay = 3;
    logic       mm_silent = 1'b0;
    logic       mm_nack = 1'b0;
    logic [7:0] mm_rdata = 8'h00;

    logic [1:0]  exp_gnt[$];
    logic [15:0] exp_cmd[$];
    done_exp_t   exp_done[$];
    done_exp_t   e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic set_req(input int idx, input logic rw, input logic [6:0] addr, input logic [7:0] wd);
        req_rw[idx]            = rw;
        req_addr[idx*7 +: 7]   = addr;
        req_wdata[idx*8 +: 8]  = wd;
    endtask

    task automatic push(input logic [1:0] g, input logic [15:0] cmd, input logic [1:0] er,
                        input logic [7:0] rd, input int lat);
        done_exp_t x;
        exp_gnt.push_back(g);
        exp_cmd.push_back(cmd);
        x.done  = g;
        x.err   = er;
        x.rdata = rd;
        x.lat   = lat;
        exp_done.push_back(x);
    endtask

    task automatic wait_dones(input string name, input int n);
        int k = 0;
        int t = 0;
        while (k < n && t < 400) begin
            @(negedge clk);
            t++;
            if (|done) k++;
        end
        check(name, 32'(k), 32'(n));
        req = 2'b00;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : master_model
        int  wait_cnt;
        logic busy;
        wait_cnt = 0;
        busy = 1'b0;
        mif.m_busy = 1'b0;
        mif.m_done = 1'b0;
        mif.m_rdata = 8'h00;
        mif.m_ack_err = 1'b0;
        forever begin
            @(negedge clk);
            mif.m_done = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (wait_cnt == 0) begin
                    mif.m_done    = 1'b1;
                    mif.m_rdata   = mm_rdata;
                    mif.m_ack_err = mm_nack;
                    busy = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (mif.m_ena && !mm_silent) begin
                busy = 1'b1;
                wait_cnt = mm_delay;
            end else if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                mif.m_done = 1'b1;
            end
            mif.m_busy = busy;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (|gnt || |done || mif.m_ena)
                check("exclusive", 32'($countones({|gnt, |done, mif.m_ena})), 32'd1);
            if (|gnt) begin
                if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
                else check("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
            end
            if (mif.m_ena) begin
                ena_cyc = cyc;
                if (exp_cmd.size() == 0) check("cmd_unexpected", 32'(mif.m_ena), 32'd0);
                else check("cmd", 32'({mif.m_rw, mif.m_addr, mif.m_wdata}), 32'(exp_cmd.pop_front()));
            end
            if (|done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_done.pop_front();
                    check("done", 32'(done), 32'(e.done));
                    check("err", 32'(err), 32'(e.err));
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    if (e.lat >= 0) check("tmo_latency", 32'(cyc - ena_cyc), 32'(e.lat));
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({gnt, done, mif.m_ena, err, rdata, mif.m_rw, mif.m_addr, mif.m_wdata}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_req(0, 1'b0, 7'h50, 8'hA5);
        mm_rdata = 8'h00;
        push(2'b01, {1'b0, 7'h50, 8'hA5}, ERR_OK, 8'h00, -1);
        req = 2'b01;
        wait_dones("write_done", 1);
        @(negedge clk);

        set_req(1, 1'b1, 7'h3C, 8'h00);
        mm_rdata = 8'h7E;
        push(2'b10, {1'b1, 7'h3C, 8'h00}, ERR_OK, 8'h7E, -1);
        req = 2'b10;
        wait_dones("read_done", 1);
        @(negedge clk);

        set_req(0, 1'b0, 7'h11, 8'h22);
        set_req(1, 1'b1, 7'h33, 8'h44);
        mm_rdata = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            push(2'b01, {1'b0, 7'h11, 8'h22}, ERR_OK, 8'h5A, -1);
            push(2'b10, {1'b1, 7'h33, 8'h44}, ERR_OK, 8'h5A, -1);
        end
        req = 2'b11;
        wait_dones("rr_done", 4);
        @(negedge clk);

        set_req(0, 1'b0, 7'h2A, 8'h0F);
        mm_rdata = 8'h99;
        mm_nack = 1'b1;
        push(2'b01, {1'b0, 7'h2A, 8'h0F}, ERR_NACK, 8'h99, -1);
        req = 2'b01;
        wait_dones("nack_done", 1);
        mm_nack = 1'b0;
        repeat (2) @(negedge clk);
        check("nack_idle", 32'(dut.state_q), 32'(ST_IDLE));

        mm_silent = 1'b1;
        set_req(0, 1'b0, 7'h10, 8'h01);
        push(2'b01, {1'b0, 7'h10, 8'h01}, ERR_TMO, 8'h99, 20);
        req = 2'b01;
        wait_dones("tmo_done", 1);
        mm_silent = 1'b0;
        @(negedge clk);

        stray_cnt++;
        repeat (5) @(negedge clk);

        set_req(0, 1'b0, 7'h01, 8'h01);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (6) @(negedge clk);

        mm_silent = 1'b1;
        set_req(1, 1'b1, 7'h3C, 8'h00);
        exp_gnt.push_back(2'b10);
        exp_cmd.push_back({1'b1, 7'h3C, 8'h00});
        req = 2'b10;
        t = 0;
        while (!mif.m_ena && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_wait_ena_seen", 32'(mif.m_ena), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check("mid_wait_reset_outputs", 32'({gnt, done, mif.m_ena, err, rdata, mif.m_rw, mif.m_addr, mif.m_wdata}), 32'd0);
        rst = 1'b0;
        mm_silent = 1'b0;
        repeat (30) @(negedge clk);

        set_req(0, 1'b0, 7'h11, 8'h22);
        mm_rdata = 8'h5A;
        push(2'b01, {1'b0, 7'h11, 8'h22}, ERR_OK, 8'h5A, -1);
        push(2'b10, {1'b1, 7'h3C, 8'h00}, ERR_OK, 8'h5A, -1);
        req = 2'b11;
        wait_dones("post_reset_done", 2);
        repeat (3) @(negedge clk);

        check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
